// File: rtl/button_conditioner.sv
// Two-channel push-button front end: 2-flop synchronizer, debouncer and
// rising-edge pulse, with auto-repeat on the next-segment channel.
//
// state     | meaning
// ST_IDLE   | no next-segment press being tracked
// ST_DELAY  | pressed; waiting REPEAT_DELAY cycles for the first repeat
// ST_REPEAT | held; emitting a repeat pulse every REPEAT_PERIOD cycles
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic clk,
   input  logic sync_nreset,
   input  logic btn_next_segment_raw,
   input  logic btn_mode_raw,
   input  logic repeat_en,
   output logic btn_next_segment_re,
   output logic btn_mode_re,
   output logic btn_next_segment_level,
   output logic btn_mode_level
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RP_W   = $clog2(RP_MAX);

   localparam logic [DB_W-1:0] DB_TC     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DELAY_TC  = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] PERIOD_TC = RP_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   // bit 0 = next-segment channel, bit 1 = mode channel
   logic [1:0]      raw;
   logic [1:0]      s1_q, s1_d;
   logic [1:0]      s2_q, s2_d;
   logic [1:0]      stable_q, stable_d;
   logic [1:0]      re_q, re_d;
   logic [1:0]      press;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];
   state_t          state_q, state_d;
   logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic            rep_pulse;

   assign raw = {btn_mode_raw, btn_next_segment_raw};

   always_comb begin
      s1_d     = raw;
      s2_d     = s1_q;
      stable_d = stable_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_TC) begin
               stable_d[i] = s2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
      press = stable_d & ~stable_q;
   end

   // A released button (stable low) always wins over the repeat timer.
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      rep_pulse = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rep_cnt_d = '0;
            if (press[0]) begin
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            if (!stable_q[0]) begin
               state_d   = ST_IDLE;
               rep_cnt_d = '0;
            end else if (!repeat_en) begin
               rep_cnt_d = '0;
            end else if (rep_cnt_q == DELAY_TC) begin
               rep_pulse = 1'b1;
               rep_cnt_d = '0;
               state_d   = ST_REPEAT;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
         end
         ST_REPEAT: begin
            if (!stable_q[0]) begin
               state_d   = ST_IDLE;
               rep_cnt_d = '0;
            end else if (!repeat_en) begin
               rep_cnt_d = '0;
            end else if (rep_cnt_q == PERIOD_TC) begin
               rep_pulse = 1'b1;
               rep_cnt_d = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            rep_cnt_d = '0;
         end
      endcase
      re_d = {press[1], press[0] | rep_pulse};
   end

   always_ff @(posedge clk) begin
      if (!sync_nreset) begin
         s1_q        <= '0;
         s2_q        <= '0;
         stable_q    <= '0;
         re_q        <= '0;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
         state_q     <= ST_IDLE;
         rep_cnt_q   <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         stable_q    <= stable_d;
         re_q        <= re_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
         state_q     <= state_d;
         rep_cnt_q   <= rep_cnt_d;
      end
   end

   assign btn_next_segment_re    = re_q[0];
   assign btn_mode_re            = re_q[1];
   assign btn_next_segment_level = stable_q[0];
   assign btn_mode_level         = stable_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized button
// activity, all checked cycle by cycle against a timestamp-based reference.
module tb_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic clk = 1'b0;
   logic sync_nreset = 1'b0;
   logic nraw = 1'b0;
   logic mraw = 1'b0;
   logic ren = 1'b0;
   logic btn_next_segment_re, btn_mode_re, btn_next_segment_level, btn_mode_level;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk                   (clk),
      .sync_nreset           (sync_nreset),
      .btn_next_segment_raw  (nraw),
      .btn_mode_raw          (mraw),
      .repeat_en             (ren),
      .btn_next_segment_re   (btn_next_segment_re),
      .btn_mode_re           (btn_mode_re),
      .btn_next_segment_level(btn_next_segment_level),
      .btn_mode_level        (btn_mode_level)
   );

   always #5 clk = ~clk;

   int cyc   = 0;
   int n_cmp = 0;
   int n_err = 0;

   // Reference: debounced level flips after DB consecutive disagreeing
   // cycles; repeats fire when (edge - anchor) reaches the delay/period.
   bit m_s1 [2];
   bit m_s2 [2];
   bit m_stable [2];
   bit m_re [2];
   int m_run [2];
   bit m_active;
   bit m_in_delay;
   int m_anchor;

   int q_next [$];
   int q_mode [$];
   bit pat [6];
   int offs [6];
   int k, k0, kr, n_hold, m_hold;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step();
      bit raw [2];
      bit nstable [2];
      bit press [2];
      bit rep;
      cyc++;
      raw[0] = nraw;
      raw[1] = mraw;
      rep = 1'b0;
      if (!sync_nreset) begin
         for (int c = 0; c < 2; c++) begin
            m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_stable[c] = 1'b0;
            m_re[c] = 1'b0; m_run[c] = 0;
         end
         m_active = 1'b0;
         m_in_delay = 1'b0;
         m_anchor = 0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            nstable[c] = m_stable[c];
            if (m_s2[c] != m_stable[c]) begin
               m_run[c]++;
               if (m_run[c] == DB) begin
                  nstable[c] = m_s2[c];
                  m_run[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
            press[c] = nstable[c] & !m_stable[c];
         end
         if (!m_active) begin
            if (press[0]) begin
               m_active = 1'b1;
               m_in_delay = 1'b1;
               m_anchor = cyc;
            end
         end else if (!m_stable[0]) begin
            m_active = 1'b0;
         end else if (!ren) begin
            m_anchor = cyc;
         end else if (cyc - m_anchor == (m_in_delay ? RD : RP)) begin
            rep = 1'b1;
            m_anchor = cyc;
            m_in_delay = 1'b0;
         end
         m_re[0] = press[0] | rep;
         m_re[1] = press[1];
         for (int c = 0; c < 2; c++) begin
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
            m_stable[c] = nstable[c];
         end
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step();
         #1;
         check("next_re",  btn_next_segment_re,    m_re[0]);
         check("mode_re",  btn_mode_re,            m_re[1]);
         check("next_lvl", btn_next_segment_level, m_stable[0]);
         check("mode_lvl", btn_mode_level,         m_stable[1]);
         if (btn_next_segment_re === 1'b1) q_next.push_back(cyc);
         if (btn_mode_re === 1'b1) q_mode.push_back(cyc);
      end
   endtask

   initial begin
      pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      offs = '{0, 10, 15, 20, 25, 30};

      // 1: reset with both buttons held, then accepted as a fresh press
      sync_nreset = 1'b0; nraw = 1'b1; mraw = 1'b1; ren = 1'b0;
      step(3);
      check("rst_next_re",  btn_next_segment_re,    1'b0);
      check("rst_mode_re",  btn_mode_re,            1'b0);
      check("rst_next_lvl", btn_next_segment_level, 1'b0);
      check("rst_mode_lvl", btn_mode_level,         1'b0);
      sync_nreset = 1'b1;
      k = cyc + 1;
      q_mode.delete(); q_next.delete();
      step(12);
      check_int("t1_mode_count", q_mode.size(), 1);
      check_int("t1_mode_lat", (q_mode.size() > 0) ? q_mode[0] - k : -1, 5);
      check("t1_mode_lvl", btn_mode_level, 1'b1);
      nraw = 1'b0; mraw = 1'b0;
      step(12);
      check("t1_release_lvl", btn_mode_level, 1'b0);

      // 2: bounce rejection, single pulse, silent release
      q_mode.delete();
      k0 = cyc + 1;
      for (int i = 0; i < 6; i++) begin
         mraw = pat[i];
         step(1);
      end
      mraw = 1'b1;
      step(12);
      check_int("t2_count", q_mode.size(), 1);
      check_int("t2_lat", (q_mode.size() > 0) ? q_mode[0] - k0 : -1, 10);
      mraw = 1'b0;
      step(12);
      check_int("t2_release_count", q_mode.size(), 1);

      // 3: auto-repeat while held
      ren = 1'b1;
      q_next.delete();
      k = cyc + 1;
      nraw = 1'b1;
      step(31);
      nraw = 1'b0;
      step(25);
      check_int("t3_count", q_next.size(), 6);
      check_int("t3_press_lat", (q_next.size() > 0) ? q_next[0] - k : -1, 5);
      for (int i = 0; i < 6; i++) begin
         check_int("t3_offset", (i < q_next.size()) ? q_next[i] - q_next[0] : -1, offs[i]);
      end
      check("t3_lvl", btn_next_segment_level, 1'b0);

      // 4: repeat disabled; mode never repeats
      ren = 1'b0;
      q_next.delete();
      nraw = 1'b1;
      step(45);
      nraw = 1'b0;
      step(12);
      check_int("t4_next_count", q_next.size(), 1);
      ren = 1'b1;
      q_mode.delete();
      mraw = 1'b1;
      step(45);
      mraw = 1'b0;
      step(12);
      check_int("t4_mode_count", q_mode.size(), 1);

      // 5: simultaneous presses
      ren = 1'b0;
      q_next.delete(); q_mode.delete();
      nraw = 1'b1; mraw = 1'b1;
      step(10);
      check_int("t5_next_count", q_next.size(), 1);
      check_int("t5_mode_count", q_mode.size(), 1);
      check_int("t5_same_cycle",
                (q_next.size() > 0 && q_mode.size() > 0) ? q_next[0] - q_mode[0] : -1, 0);
      nraw = 1'b0; mraw = 1'b0;
      step(12);

      // 6: one-cycle reset while repeating with the button held
      ren = 1'b1;
      q_next.delete();
      k = cyc + 1;
      nraw = 1'b1;
      step(17);
      sync_nreset = 1'b0;
      step(1);
      check("t6_rst_re",  btn_next_segment_re,    1'b0);
      check("t6_rst_lvl", btn_next_segment_level, 1'b0);
      sync_nreset = 1'b1;
      kr = cyc + 1;
      step(20);
      check_int("t6_count", q_next.size(), 4);
      check_int("t6_first_repeat", (q_next.size() > 1) ? q_next[1] - q_next[0] : -1, 10);
      check_int("t6_press_lat", (q_next.size() > 2) ? q_next[2] - kr : -1, 5);
      check_int("t6_repeat_restart", (q_next.size() > 3) ? q_next[3] - q_next[2] : -1, 10);
      nraw = 1'b0;
      step(15);

      // randomized activity against the reference
      n_hold = 0;
      m_hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (n_hold == 0) begin
            nraw = ~nraw;
            n_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 45))
                                                 : int'($urandom_range(1, 6));
         end else begin
            n_hold--;
         end
         if (m_hold == 0) begin
            mraw = ~mraw;
            m_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 30))
                                                 : int'($urandom_range(1, 5));
         end else begin
            m_hold--;
         end
         if ($urandom_range(0, 60) == 0) ren = ~ren;
         sync_nreset = ($urandom_range(0, 299) != 0);
         step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
